// File: rtl/gps_sched_pkg.sv
// gps_sched_pkg: register map, CTRL bit positions and saturating MISSED arithmetic shared by the GPS scheduler
package gps_sched_pkg;
   localparam logic [2:0] REG_CTRL      = 3'd0;
   localparam logic [2:0] REG_TIC_DIV   = 3'd1;
   localparam logic [2:0] REG_ACCUM_DIV = 3'd2;
   localparam logic [2:0] REG_STATUS    = 3'd3;
   localparam logic [2:0] REG_MISSED    = 3'd4;
   localparam logic [2:0] REG_TIC_COUNT = 3'd5;
   localparam logic [2:0] REG_ACCUM_ACK = 3'd6;
   localparam int CTRL_TIC_EN   = 0;
   localparam int CTRL_ACCUM_EN = 1;
   localparam int CTRL_INT_EN   = 2;
   localparam logic [15:0] MISSED_MAX = 16'hFFFF;
   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {12'b0, b};
      return s[16] ? MISSED_MAX : s[15:0];
   endfunction
endpackage

// File: rtl/gps_sched_divider.sv
// gps_sched_divider: free-running period counter, hit marks the cycle the count reaches period
module gps_sched_divider #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] period,
   output logic         hit
);
   logic [W-1:0] cnt;
   assign hit = en & ~clr & (cnt == period);
   always_ff @(posedge clk)
      if (rst) cnt <= '0;
      else cnt <= (!en || clr || hit) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/gps_accum_scheduler.sv
// gps_accum_scheduler: TIC/accumulation timing, dump-flag latching and WISHBONE register file for the correlators
module gps_accum_scheduler
   import gps_sched_pkg::*;
#(
   parameter int NCH           = 12,
   parameter int DIV_W         = 24,
   parameter int TIC_DEFAULT   = 4999999,
   parameter int ACCUM_DEFAULT = 24999
) (
   input  logic           sys_clk,
   input  logic           sys_rst,
   input  logic [2:0]     wb_adr_i,
   input  logic [31:0]    wb_dat_i,
   output logic [31:0]    wb_dat_o,
   input  logic           wb_stb_i,
   input  logic           wb_cyc_i,
   input  logic           wb_we_i,
   output logic           wb_ack_o,
   input  logic [NCH-1:0] dump_i,
   output logic           tic_o,
   output logic           accum_int_o,
   output logic           gps_led
);
   logic [2:0]       ctrl;
   logic [DIV_W-1:0] tic_div, accum_div;
   logic [NCH-1:0]   dump_flags, overrun;
   logic             tic_seen;
   logic [15:0]      missed;
   logic [31:0]      tic_count, rdata;
   logic [4:0]       pop;
   logic             tic_hit, accum_hit, xfer, wr;
   logic             wr_ctrl, wr_tic_div, wr_accum_div, wr_status, wr_missed, wr_ack;
   logic             unused_bits;
   assign unused_bits  = ^wb_dat_i;
   assign xfer         = wb_stb_i & wb_cyc_i & ~wb_ack_o;
   assign wr           = xfer & wb_we_i;
   assign wr_ctrl      = wr && wb_adr_i == REG_CTRL;
   assign wr_tic_div   = wr && wb_adr_i == REG_TIC_DIV;
   assign wr_accum_div = wr && wb_adr_i == REG_ACCUM_DIV;
   assign wr_status    = wr && wb_adr_i == REG_STATUS;
   assign wr_missed    = wr && wb_adr_i == REG_MISSED;
   assign wr_ack       = wr && wb_adr_i == REG_ACCUM_ACK;
   // an overrun is a dump arriving on a flag the CPU has not yet cleared
   assign overrun = dump_i & dump_flags;
   always_comb begin
      pop = '0;
      for (int i = 0; i < NCH; i++) pop = pop + 5'(overrun[i]);
   end
   always_comb begin
      rdata = '0;
      case (wb_adr_i)
         REG_CTRL:      rdata = 32'(ctrl);
         REG_TIC_DIV:   rdata = 32'(tic_div);
         REG_ACCUM_DIV: rdata = 32'(accum_div);
         REG_STATUS:    rdata = {tic_seen, 31'(dump_flags)};
         REG_MISSED:    rdata = 32'(missed);
         REG_TIC_COUNT: rdata = tic_count;
         default:       rdata = '0;
      endcase
   end
   gps_sched_divider #(.W(DIV_W)) u_tic (
      .clk(sys_clk), .rst(sys_rst), .en(ctrl[CTRL_TIC_EN]), .clr(wr_tic_div),
      .period(tic_div), .hit(tic_hit)
   );
   gps_sched_divider #(.W(DIV_W)) u_accum (
      .clk(sys_clk), .rst(sys_rst), .en(ctrl[CTRL_ACCUM_EN]), .clr(wr_accum_div),
      .period(accum_div), .hit(accum_hit)
   );
   // sets are OR-ed in after clears so a coincident event always survives
   always_ff @(posedge sys_clk)
      if (sys_rst) begin
         wb_ack_o    <= 1'b0;
         wb_dat_o    <= '0;
         ctrl        <= '0;
         tic_div     <= DIV_W'(TIC_DEFAULT);
         accum_div   <= DIV_W'(ACCUM_DEFAULT);
         dump_flags  <= '0;
         tic_seen    <= 1'b0;
         missed      <= '0;
         tic_count   <= '0;
         tic_o       <= 1'b0;
         gps_led     <= 1'b0;
         accum_int_o <= 1'b0;
      end else begin
         wb_ack_o    <= xfer;
         if (xfer) wb_dat_o <= rdata;
         if (wr_ctrl) ctrl <= wb_dat_i[2:0];
         if (wr_tic_div) tic_div <= wb_dat_i[DIV_W-1:0];
         if (wr_accum_div) accum_div <= wb_dat_i[DIV_W-1:0];
         dump_flags  <= (dump_flags & ~(wr_status ? wb_dat_i[NCH-1:0] : '0)) | dump_i;
         tic_seen    <= (tic_seen & ~(wr_status & wb_dat_i[31])) | tic_hit;
         missed      <= sat_add16(wr_missed ? 16'd0 : missed, pop);
         tic_o       <= tic_hit;
         if (tic_hit) tic_count <= tic_count + 1'b1;
         if (tic_hit) gps_led <= ~gps_led;
         accum_int_o <= (accum_int_o & ~wr_ack) | (accum_hit & ctrl[CTRL_INT_EN]);
      end
endmodule

// File: tb/tb_gps_accum_scheduler.sv
// tb_gps_accum_scheduler: directed register vectors plus hand-timed divider, dump and reset sequences
module tb_gps_accum_scheduler;
   import gps_sched_pkg::*;
   localparam int NCH = 12;
   logic           sys_clk = 1'b0, sys_rst = 1'b1;
   logic [2:0]     wb_adr_i = '0;
   logic [31:0]    wb_dat_i = '0, wb_dat_o, q;
   logic           wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0, wb_ack_o;
   logic [NCH-1:0] dump_i = '0;
   logic           tic_o, accum_int_o, gps_led;
   int             vectors = 0, errs = 0;
   typedef struct {
      logic        we;
      logic [2:0]  adr;
      logic [31:0] d;
      logic        cmp;
      logic [31:0] exp;
   } vec_t;
   vec_t tv[22];

   always #5 sys_clk = ~sys_clk;

   gps_accum_scheduler #(.NCH(NCH)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
      .wb_dat_o(wb_dat_o), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
      .wb_ack_o(wb_ack_o), .dump_i(dump_i), .tic_o(tic_o), .accum_int_o(accum_int_o),
      .gps_led(gps_led)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic on, input logic we, input logic [2:0] a, input logic [31:0] d);
      wb_stb_i = on; wb_cyc_i = on; wb_we_i = we; wb_adr_i = a; wb_dat_i = d;
   endtask

   task automatic bus(input logic we, input logic [2:0] a, input logic [31:0] d, output logic [31:0] r);
      int n = 0;
      @(negedge sys_clk);
      drive(1'b1, we, a, d);
      do begin
         @(negedge sys_clk);
         n++;
      end while (!wb_ack_o && n < 4);
      chk("ack_latency", 32'(n), 32'd1);
      r = wb_dat_o;
      drive(1'b0, 1'b0, 3'd0, 32'h0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      logic [31:0] r;
      bus(1'b1, a, d, r);
   endtask

   task automatic rd(input string nm, input logic [2:0] a, input logic [31:0] exp);
      logic [31:0] r;
      bus(1'b0, a, 32'h0, r);
      chk(nm, r, exp);
   endtask

   task automatic pulse_dump(input logic [NCH-1:0] v);
      @(negedge sys_clk);
      dump_i = v;
      @(negedge sys_clk);
      dump_i = '0;
   endtask

   initial begin
      logic [3:0] p;
      logic [4:1] a;
      int n, last, pulses;
      tv[0]  = '{1'b0, REG_CTRL,      32'h0,        1'b1, 32'h0};
      tv[1]  = '{1'b0, REG_TIC_DIV,   32'h0,        1'b1, 32'd4999999};
      tv[2]  = '{1'b0, REG_ACCUM_DIV, 32'h0,        1'b1, 32'd24999};
      tv[3]  = '{1'b0, REG_STATUS,    32'h0,        1'b1, 32'h0};
      tv[4]  = '{1'b0, REG_MISSED,    32'h0,        1'b1, 32'h0};
      tv[5]  = '{1'b0, REG_TIC_COUNT, 32'h0,        1'b1, 32'h0};
      tv[6]  = '{1'b0, REG_ACCUM_ACK, 32'h0,        1'b1, 32'h0};
      tv[7]  = '{1'b0, 3'd7,          32'h0,        1'b1, 32'h0};
      tv[8]  = '{1'b1, REG_TIC_DIV,   32'hFFFFFFFF, 1'b0, 32'h0};
      tv[9]  = '{1'b0, REG_TIC_DIV,   32'h0,        1'b1, 32'h00FFFFFF};
      tv[10] = '{1'b1, REG_CTRL,      32'hFFFFFFF8, 1'b0, 32'h0};
      tv[11] = '{1'b0, REG_CTRL,      32'h0,        1'b1, 32'h0};
      tv[12] = '{1'b1, 3'd7,          32'hFFFFFFFF, 1'b0, 32'h0};
      tv[13] = '{1'b0, 3'd7,          32'h0,        1'b1, 32'h0};
      tv[14] = '{1'b1, REG_TIC_COUNT, 32'h12345678, 1'b0, 32'h0};
      tv[15] = '{1'b0, REG_TIC_COUNT, 32'h0,        1'b1, 32'h0};
      tv[16] = '{1'b1, REG_ACCUM_DIV, 32'hFF000003, 1'b0, 32'h0};
      tv[17] = '{1'b0, REG_ACCUM_DIV, 32'h0,        1'b1, 32'h3};
      tv[18] = '{1'b1, REG_TIC_DIV,   32'h9,        1'b0, 32'h0};
      tv[19] = '{1'b0, REG_TIC_DIV,   32'h0,        1'b1, 32'h9};
      tv[20] = '{1'b1, REG_ACCUM_ACK, 32'hFFFFFFFF, 1'b0, 32'h0};
      tv[21] = '{1'b0, REG_ACCUM_ACK, 32'h0,        1'b1, 32'h0};

      repeat (3) @(negedge sys_clk);
      chk("rst_dat_o", wb_dat_o, 32'h0);
      chk("rst_outs", {28'h0, wb_ack_o, tic_o, accum_int_o, gps_led}, 32'h0);
      sys_rst = 1'b0;
      for (int i = 0; i < 22; i++) begin
         bus(tv[i].we, tv[i].adr, tv[i].d, q);
         if (tv[i].cmp) chk($sformatf("vec%0d", i), q, tv[i].exp);
      end

      // held strobe must see ack on alternate cycles only
      @(negedge sys_clk);
      drive(1'b1, 1'b0, REG_CTRL, 32'h0);
      for (int i = 3; i >= 0; i--) begin
         @(negedge sys_clk);
         p[i] = wb_ack_o;
      end
      drive(1'b0, 1'b0, 3'd0, 32'h0);
      chk("ack_no_b2b", 32'(p), 32'hA);

      wr(REG_CTRL, 32'h1);
      n = 0; last = 0; pulses = 0;
      while (pulses < 5 && n < 200) begin
         @(negedge sys_clk);
         n++;
         if (tic_o) begin
            chk("tic_period", 32'(n - last), 32'd10);
            last = n;
            pulses++;
         end
      end
      chk("tic_pulses", 32'(pulses), 32'd5);
      wr(REG_CTRL, 32'h0);
      rd("tic_count", REG_TIC_COUNT, 32'd5);
      rd("tic_seen", REG_STATUS, 32'h80000000);
      chk("gps_led", 32'(gps_led), 32'h1);

      wr(REG_ACCUM_DIV, 32'h3);
      wr(REG_CTRL, 32'h6);
      for (int i = 1; i <= 4; i++) begin
         @(negedge sys_clk);
         a[i] = accum_int_o;
      end
      chk("accum_rise", 32'(a), 32'h8);
      @(negedge sys_clk);
      drive(1'b1, 1'b1, REG_ACCUM_ACK, 32'h0);
      @(negedge sys_clk);
      chk("ack_write_ack", 32'(wb_ack_o), 32'h1);
      chk("accum_ack_clr", 32'(accum_int_o), 32'h0);
      drive(1'b0, 1'b0, 3'd0, 32'h0);
      @(negedge sys_clk);
      chk("accum_still_low", 32'(accum_int_o), 32'h0);
      @(negedge sys_clk);
      chk("accum_reassert", 32'(accum_int_o), 32'h1);
      repeat (3) @(negedge sys_clk);
      drive(1'b1, 1'b1, REG_ACCUM_ACK, 32'h0);
      @(negedge sys_clk);
      chk("coinc_ack", 32'(wb_ack_o), 32'h1);
      chk("accum_set_wins", 32'(accum_int_o), 32'h1);
      drive(1'b0, 1'b0, 3'd0, 32'h0);
      wr(REG_CTRL, 32'h2);
      chk("int_en_clr_holds", 32'(accum_int_o), 32'h1);
      wr(REG_ACCUM_ACK, 32'h0);
      chk("accum_ack2", 32'(accum_int_o), 32'h0);
      repeat (10) @(negedge sys_clk);
      chk("accum_masked", 32'(accum_int_o), 32'h0);
      wr(REG_CTRL, 32'h0);

      wr(REG_STATUS, 32'hFFFFFFFF);
      rd("status_cleared", REG_STATUS, 32'h0);
      pulse_dump(12'h004);
      pulse_dump(12'h004);
      rd("dump_flag", REG_STATUS, 32'h4);
      rd("missed_one", REG_MISSED, 32'd1);
      wr(REG_STATUS, 32'h4);
      rd("w1c_clear", REG_STATUS, 32'h0);
      pulse_dump(12'h004);
      @(negedge sys_clk);
      drive(1'b1, 1'b1, REG_STATUS, 32'h4);
      dump_i = 12'h004;
      @(negedge sys_clk);
      chk("w1c_coinc_ack", 32'(wb_ack_o), 32'h1);
      drive(1'b0, 1'b0, 3'd0, 32'h0);
      dump_i = '0;
      rd("dump_set_wins", REG_STATUS, 32'h4);
      rd("missed_two", REG_MISSED, 32'd2);
      pulse_dump(12'h00B);
      pulse_dump(12'h00F);
      rd("multi_flags", REG_STATUS, 32'hF);
      rd("missed_popcount", REG_MISSED, 32'd6);

      @(negedge sys_clk);
      dump_i = 12'h001;
      repeat (70000) @(negedge sys_clk);
      dump_i = '0;
      rd("missed_sat", REG_MISSED, 32'h0000FFFF);
      wr(REG_MISSED, 32'h0);
      rd("missed_clr", REG_MISSED, 32'h0);

      wr(REG_TIC_DIV, 32'h0);
      wr(REG_ACCUM_DIV, 32'h0);
      wr(REG_CTRL, 32'h7);
      for (int i = 0; i < 3; i++) begin
         @(negedge sys_clk);
         chk("tic_div0", 32'(tic_o), 32'h1);
      end
      chk("accum_div0", 32'(accum_int_o), 32'h1);
      @(negedge sys_clk);
      sys_rst = 1'b1;
      drive(1'b1, 1'b0, REG_TIC_DIV, 32'h0);
      @(negedge sys_clk);
      chk("rst_mid_xfer", {28'h0, wb_ack_o, tic_o, accum_int_o, gps_led}, 32'h0);
      sys_rst = 1'b0;
      drive(1'b0, 1'b0, 3'd0, 32'h0);
      @(negedge sys_clk);
      chk("rst_no_late_ack", 32'(wb_ack_o), 32'h0);
      for (int i = 0; i < 8; i++) begin
         bus(tv[i].we, tv[i].adr, tv[i].d, q);
         chk($sformatf("post_rst%0d", i), q, tv[i].exp);
      end
      chk("post_rst_accum", 32'(accum_int_o), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/gps_accum_scheduler.md
Name: gps_accum_scheduler

Overview:
- Timing and interrupt controller for the GPS correlator channels.
- Generates the measurement epoch (TIC) pulse and the periodic accumulation interrupt from programmable dividers on sys_clk.
- Latches per-channel dump-ready flags and counts overrun (missed) dumps.
- Exposes a small WISHBONE register file so the CPU can configure the schedule, read status and acknowledge interrupts.

Parameters:
- NCH, 12, number of correlator channels (1..16)
- DIV_W, 24, width of the TIC and ACCUM divider registers and counters
- TIC_DEFAULT, 4999999, reset value of TIC_DIV (100 ms at 50 MHz)
- ACCUM_DEFAULT, 24999, reset value of ACCUM_DIV (0.5 ms at 50 MHz)

Ports:
- sys_clk  in  1  system clock; the only clock
- sys_rst  in  1  synchronous, active-high reset
- wb_adr_i  in  3  word address (byte address bits [4:2])
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle
- wb_we_i  in  1  write enable
- wb_ack_o  out  1  acknowledge
- dump_i  in  NCH  one-cycle dump-ready pulse per channel
- tic_o  out  1  one-cycle epoch pulse to all channels (latch measurements)
- accum_int_o  out  1  level interrupt to CPU
- gps_led  out  1  toggles on every TIC

Behaviour:
Reset (sys_rst sampled high at a clock edge):
- CTRL=0, TIC_DIV=TIC_DEFAULT, ACCUM_DIV=ACCUM_DEFAULT, all counters=0, STATUS=0, MISSED=0, TIC_COUNT=0.
- All outputs 0, including wb_ack_o.
- Reset mid-transfer aborts the transfer: no ack is issued.

Register map (word address):
- 0 CTRL (rw): bit0 tic_en, bit1 accum_en, bit2 int_en.
- 1 TIC_DIV (rw): period-1 in cycles. A write also clears the tic counter.
- 2 ACCUM_DIV (rw): period-1 in cycles. A write also clears the accum counter.
- 3 STATUS (r, W1C): bits [NCH-1:0] sticky dump flags; bit31 sticky tic_seen.
- 4 MISSED (r): 16-bit saturating overrun count. Any write clears it.
- 5 TIC_COUNT (r): 32-bit wrapping TIC count.
- 6 ACCUM_ACK (w): any write clears accum_int_o. Reads return 0.
- 7 reserved: reads 0, writes ignored.
- Bits above DIV_W/NCH/16 read as 0. Unused bits of writable registers are ignored.

WISHBONE:
- ack = registered (stb & cyc & !ack): one wait state, ack high for exactly 1 cycle, no back-to-back ack.
- wb_dat_o is registered and valid in the ack cycle; it holds its value otherwise.
- Writes take effect at the edge where ack is asserted.

Dividers:
- When tic_en=1 the counter increments each cycle. When it equals TIC_DIV, next cycle tic_o=1 for one cycle, the counter returns to 0, gps_led toggles, TIC_COUNT increments, and STATUS[31] is set.
- Period = TIC_DIV+1 cycles. DIV=0 gives tic_o high every cycle.
- tic_en=0 holds the counter at 0 and forces tic_o=0.
- The ACCUM divider is identical, gated by accum_en. Its terminal event sets accum_int_o only if int_en=1.

Dump flags:
- dump_i[k] sets STATUS[k].
- If STATUS[k] is already 1 when dump_i[k] arrives, MISSED increments, saturating at 0xFFFF. Multiple simultaneous overruns in one cycle add popcount, saturating.

Simultaneous events:
- A set (dump or accum terminal event) in the same cycle as W1C/ACK: set wins.
- Clearing int_en does not drop an already-asserted accum_int_o; only ACCUM_ACK or reset does.

Decomposition:
- Shared package gps_sched_pkg holds the register address constants (REG_CTRL..REG_ACCUM_ACK), CTRL bit indices, and MISSED_MAX=16'hFFFF.
- One natural sub-module, gps_sched_divider (enable, period, clear -> terminal pulse), instantiated twice for TIC and ACCUM.

Test Plan:
- Reset then read all registers -> CTRL=0, TIC_DIV=4999999, ACCUM_DIV=24999, others 0; each access acked exactly 1 cycle after stb.
- Write TIC_DIV=9, CTRL=1 -> tic_o pulses every 10 cycles; after 5 pulses TIC_COUNT=5, gps_led toggled 5 times, STATUS[31]=1.
- Write ACCUM_DIV=3, CTRL=6 -> accum_int_o rises 4 cycles after enable and stays high; ACCUM_ACK write drops it; an ACK coincident with a terminal event leaves it high.
- Pulse dump_i[2] twice without clearing -> STATUS[2]=1, MISSED=1. W1C 0x4 -> STATUS[2]=0. W1C coincident with a dump on bit 2 -> STATUS[2] stays 1.
- Drive 70000 overrun pulses on dump_i[0] -> MISSED saturates at 0xFFFF. Any write to MISSED -> 0.
- Assert sys_rst during a pending WISHBONE read and with accum_int_o high -> no ack, accum_int_o=0, all registers at reset values next cycle.
